// File: rtl/ccff_chain_loader_pkg.sv
// Shared types for the configuration-chain loader.
// Holds the FSM state encoding used by the top.
package ccff_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ccff_chain_loader_piso.sv
// Parallel-in serial-out word register, MSB first.
// Tracks how many bits of the loaded word are still unsent.
module ccff_piso #(
  parameter  int WORD_W = 8,
  localparam int REM_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              msb,
  output logic              msb_next,
  output logic [REM_W-1:0]  rem
);

  logic [WORD_W-1:0] q;
  logic [WORD_W-1:0] q_sh;

  assign q_sh     = q << 1;
  assign msb      = q[WORD_W-1];
  assign msb_next = q_sh[WORD_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      rem <= '0;
    end else if (load) begin
      q   <= din;
      rem <= REM_W'(WORD_W);
    end else if (shift) begin
      q   <= q_sh;
      rem <= rem - 1'b1;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words onto the tile ccff chain head and,
// on verify passes, compares the returning tail bit.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 16,
  parameter int ERR_W     = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_fail,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int REM_W = $clog2(WORD_W + 1);

  state_t             state;
  logic [CNT_W-1:0]   bits;
  logic [CNT_W-1:0]   bits_n;
  logic [REM_W-1:0]   rem;
  logic               verify_q;
  logic               hs;
  logic               piso_msb;
  logic               piso_msb_next;
  logic               chain_full;
  logic               word_end;
  logic               mismatch;

  assign hs         = cfg_ready & cfg_valid;
  assign bits_n     = bits + 1'b1;
  assign chain_full = (bits_n == CNT_W'(CHAIN_LEN));
  assign word_end   = (rem == REM_W'(1));

  // Tail is the pre-edge content of the last flop, so it lines
  // up with the bit being driven when host resends the stream.
  assign mismatch = ccff_shift_en & verify_q
                  & (ccff_tail != piso_msb);

  ccff_piso #(
    .WORD_W(WORD_W)
  ) u_piso (
    .clk      (prog_clk),
    .rst      (pReset),
    .load     (hs),
    .shift    (state == ST_SHIFT),
    .din      (cfg_data),
    .msb      (piso_msb),
    .msb_next (piso_msb_next),
    .rem      (rem)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= ST_IDLE;
      bits          <= '0;
      verify_q      <= 1'b0;
      cfg_ready     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      verify_fail   <= 1'b0;
      err_count     <= '0;
    end else begin
      done <= 1'b0;
      if (mismatch) begin
        verify_fail <= 1'b1;
        if (err_count != '1)
          err_count <= err_count + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            verify_q    <= verify;
            err_count   <= '0;
            verify_fail <= 1'b0;
            bits        <= '0;
            busy        <= 1'b1;
            cfg_ready   <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cfg_valid) begin
            cfg_ready     <= 1'b0;
            ccff_head     <= cfg_data[WORD_W-1];
            ccff_shift_en <= 1'b1;
            state         <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bits <= bits_n;
          if (chain_full) begin
            ccff_shift_en <= 1'b0;
            done          <= 1'b1;
            state         <= ST_DONE;
          end else if (word_end) begin
            ccff_shift_en <= 1'b0;
            cfg_ready     <= 1'b1;
            state         <= ST_WAIT;
          end else begin
            ccff_head <= piso_msb_next;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed and random passes against behavioural ccff chains
// of 16 and 20 flops driven by the loader outputs.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b1;
  logic       verify   = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       start16  = 1'b0;
  logic       start20  = 1'b0;

  always #5 prog_clk = ~prog_clk;

  logic       ready16, head16, sen16, busy16, done16, vf16;
  logic [7:0] err16;
  logic       ready20, head20, sen20, busy20, done20, vf20;
  logic [7:0] err20;

  logic [15:0] chain16 = '0;
  logic [19:0] chain20 = '0;

  ccff_chain_loader #(
    .WORD_W(8), .CHAIN_LEN(16), .ERR_W(8)
  ) u16 (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start16),
    .verify        (verify),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (ready16),
    .ccff_head     (head16),
    .ccff_shift_en (sen16),
    .ccff_tail     (chain16[15]),
    .busy          (busy16),
    .done          (done16),
    .verify_fail   (vf16),
    .err_count     (err16)
  );

  ccff_chain_loader #(
    .WORD_W(8), .CHAIN_LEN(20), .ERR_W(8)
  ) u20 (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start20),
    .verify        (verify),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (ready20),
    .ccff_head     (head20),
    .ccff_shift_en (sen20),
    .ccff_tail     (chain20[19]),
    .busy          (busy20),
    .done          (done20),
    .verify_fail   (vf20),
    .err_count     (err20)
  );

  int cyc = 0;
  int sc16 = 0, dc16 = 0, hs16 = 0;
  int sc20 = 0, dc20 = 0, hs20 = 0;
  int st16 = 0, dn16 = 0, st20 = 0, dn20 = 0;

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (sen16) begin
      chain16 <= {chain16[14:0], head16};
      sc16    <= sc16 + 1;
    end
    if (sen20) begin
      chain20 <= {chain20[18:0], head20};
      sc20    <= sc20 + 1;
    end
    if (done16) begin dc16 <= dc16 + 1; dn16 <= cyc; end
    if (done20) begin dc20 <= dc20 + 1; dn20 <= cyc; end
    if (start16 && !busy16) st16 <= cyc;
    if (start20 && !busy20) st20 <= cyc;
    if (cfg_valid && ready16) hs16 <= hs16 + 1;
    if (cfg_valid && ready20) hs20 <= hs20 + 1;
  end

  bit         use20 = 1'b0;
  logic       rdy, sen, bsy, vf;
  logic [7:0] err;
  logic [19:0] chn;
  assign rdy = use20 ? ready20 : ready16;
  assign sen = use20 ? sen20   : sen16;
  assign bsy = use20 ? busy20  : busy16;
  assign vf  = use20 ? vf20    : vf16;
  assign err = use20 ? err20   : err16;
  assign chn = use20 ? chain20 : {4'h0, chain16};

  int checks = 0;
  int failures = 0;
  int b_sc, b_dc, b_hs;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic snap_counts();
    b_sc = use20 ? sc20 : sc16;
    b_dc = use20 ? dc20 : dc16;
    b_hs = use20 ? hs20 : hs16;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (rdy !== 1'b1 && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    if (t >= 200) tmo("wait_ready");
  endtask

  task automatic offer(input logic [7:0] w);
    cfg_data  = w;
    cfg_valid = 1'b1;
    wait_ready();
    @(negedge prog_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit sel, input bit v);
    use20  = sel;
    verify = v;
    snap_counts();
    if (sel) start20 = 1'b1;
    else     start16 = 1'b1;
    @(negedge prog_clk);
    start16 = 1'b0;
    start20 = 1'b0;
  endtask

  task automatic do_pass(input bit sel, input bit v,
                         input logic [7:0] w0,
                         input logic [7:0] w1,
                         input logic [7:0] w2,
                         input int nw, input int stall);
    logic [7:0]  w [3];
    logic [19:0] snap;
    w[0] = w0; w[1] = w1; w[2] = w2;
    pulse_start(sel, v);
    for (int i = 0; i < nw; i++) begin
      if (i > 0 && stall > 0) begin
        wait_ready();
        snap = chn;
        repeat (stall) begin
          @(negedge prog_clk);
          chk("stall_shift_en", {31'd0, sen}, 32'd0);
          chk("stall_chain", {12'd0, chn}, {12'd0, snap});
        end
      end
      offer(w[i]);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bsy !== 1'b0 && t < 300) begin
      @(negedge prog_clk);
      t++;
    end
    if (t >= 300) tmo("wait_idle");
  endtask

  task automatic check_pass(input logic [19:0] exp_chain,
                            input int exp_err,
                            input int exp_shifts,
                            input int exp_hs);
    int sc, dc, hs;
    wait_idle();
    @(negedge prog_clk);
    sc = use20 ? sc20 : sc16;
    dc = use20 ? dc20 : dc16;
    hs = use20 ? hs20 : hs16;
    chk("shift_count", sc - b_sc, exp_shifts);
    chk("done_pulses", dc - b_dc, 1);
    chk("handshakes", hs - b_hs, exp_hs);
    chk("chain", {12'd0, chn}, {12'd0, exp_chain});
    chk("err_count", {24'd0, err}, exp_err);
    chk("verify_fail", {31'd0, vf}, {31'd0, exp_err != 0});
    chk("ready_idle", {31'd0, rdy}, 32'd0);
  endtask

  logic [7:0]  rw0, rw1;
  logic [15:0] old16, stream;
  bit          rv;
  int          rstall, pops, t6, dc_hold;

  initial begin
    repeat (3) @(negedge prog_clk);
    chk("rst_ready", {26'd0, ready16, head16, sen16,
        busy16, done16, vf16}, 32'd0);
    chk("rst_err", {24'd0, err16}, 32'd0);
    chk("rst20", {18'd0, err20, ready20, head20, sen20,
        busy20, done20, vf20}, 32'd0);
    pReset = 1'b0;
    @(negedge prog_clk);

    // 1: load A5,3C
    do_pass(0, 0, 8'hA5, 8'h3C, 8'h00, 2, 0);
    check_pass(20'h0A53C, 0, 16, 2);
    chk("pass_len16", dn16 - st16, 19);

    // 2: verify same stream
    do_pass(0, 1, 8'hA5, 8'h3C, 8'h00, 2, 0);
    check_pass(20'h0A53C, 0, 16, 2);

    // 3: verify with one bad bit
    do_pass(0, 1, 8'hA5, 8'h3D, 8'h00, 2, 0);
    check_pass(20'h0A53D, 1, 16, 2);

    // 6: reset after bit 9
    pulse_start(0, 0);
    offer(8'hF0);
    offer(8'h0F);
    t6 = 0;
    while (sc16 - b_sc < 9 && t6 < 100) begin
      @(negedge prog_clk);
      t6++;
    end
    if (t6 >= 100) tmo("wait_bit9");
    dc_hold = dc16;
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    chk("abort_outs", {26'd0, ready16, head16, sen16,
        busy16, done16, vf16}, 32'd0);
    chk("abort_err", {24'd0, err16}, 32'd0);
    repeat (25) @(negedge prog_clk);
    chk("abort_no_done", dc16, dc_hold);
    chk("abort_idle", {31'd0, busy16}, 32'd0);
    do_pass(0, 0, 8'h96, 8'h69, 8'h00, 2, 0);
    check_pass(20'h09669, 0, 16, 2);

    // 4: stall 5 cycles between words
    do_pass(0, 0, 8'h5A, 8'hC3, 8'h00, 2, 5);
    check_pass(20'h05AC3, 0, 16, 2);

    // 5: 20-flop chain, partial last word, extra word
    do_pass(1, 0, 8'hFF, 8'h00, 8'hA0, 3, 0);
    cfg_data  = 8'h55;
    cfg_valid = 1'b1;
    repeat (40) @(negedge prog_clk);
    chk("extra_not_taken", {31'd0, rdy}, 32'd0);
    cfg_valid = 1'b0;
    check_pass(20'hFF00A, 0, 20, 3);
    chk("pass_len20", dn20 - st20, 24);

    // random load/verify passes on the 16-flop chain
    for (int k = 0; k < 10; k++) begin
      old16  = chain16;
      rv     = 1'($urandom_range(0, 1));
      rstall = $urandom_range(0, 3);
      if (rv && $urandom_range(0, 1) == 1)
        stream = old16 ^ (16'h1 << $urandom_range(0, 15))
                       ^ (16'h1 << $urandom_range(0, 15));
      else
        stream = 16'($urandom);
      rw0  = stream[15:8];
      rw1  = stream[7:0];
      pops = rv ? $countones(old16 ^ stream) : 0;
      do_pass(0, rv, rw0, rw1, 8'h00, 2, rstall);
      check_pass({4'h0, stream}, pops, 16, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
